// File: rtl/pio_ctrl_pkg.sv
// Shared definitions for the push-button/switch input PIO controller.
//   pio_addr_e              : Avalon word addresses of the register map
//   DEFAULT_DEBOUNCE_CYCLES : default debounce length in clk cycles
package pio_ctrl_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_IRQMASK = 2'd1,
    ADDR_RSVD    = 2'd2,
    ADDR_EDGECAP = 2'd3
  } pio_addr_e;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 50000;

endpackage

// File: rtl/pio_debounce_bit.sv
// One input bit: 2-flop synchroniser, debounce counter and stable flop.
//   clk_i    : system clock
//   rst_ni   : synchronous active-low reset
//   in_i     : raw asynchronous input
//   stable_o : debounced level
//   rise_o   : high in the cycle whose clock edge takes stable_o 0->1
module pio_debounce_bit
  import pio_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in_i,
  output logic stable_o,
  output logic rise_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (s2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= in_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  // Taken from next-state so edge capture lands on the same edge as stable.
  assign rise_o   = stable_d & ~stable_q;

endmodule

// File: rtl/pio_edge_irq_ctrl.sv
// Avalon-MM slave for the debounced input PIO with rising-edge interrupt.
//   clk, reset_n        : clock, synchronous active-low reset
//   address, chipselect,
//   write, writedata    : Avalon slave write side (no wait states)
//   readdata            : registered read data, 1-cycle latency
//   in_port             : raw asynchronous board inputs
//   irq                 : level interrupt, |(edgecapture & irq_mask)
// Map: 0 DATA (RO), 1 IRQMASK (RW), 2 reserved (reads 0), 3 EDGECAP (W1C).
module pio_edge_irq_ctrl
  import pio_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [WIDTH-1:0] stable, rise;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] clr_mask;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_en;
  // Write data above WIDTH has no storage behind it.
  logic [31:0]      unused_writedata;

  assign unused_writedata = writedata;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    pio_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk_i   (clk),
      .rst_ni  (reset_n),
      .in_i    (in_port[g]),
      .stable_o(stable[g]),
      .rise_o  (rise[g])
    );
  end

  assign wr_en = chipselect && write;

  always_comb begin
    irq_mask_d = irq_mask_q;
    clr_mask   = '0;
    if (wr_en) begin
      case (pio_addr_e'(address))
        ADDR_IRQMASK: irq_mask_d = writedata[WIDTH-1:0];
        ADDR_EDGECAP: clr_mask   = writedata[WIDTH-1:0];
        default:      ;
      endcase
    end
    // Set is applied after clear so a coincident rise wins.
    edgecap_d = (edgecap_q & ~clr_mask) | rise;
  end

  // Mux uses pre-write register values, so a read during a write sees old data.
  always_comb begin
    readdata_d = '0;
    case (pio_addr_e'(address))
      ADDR_DATA:    readdata_d[WIDTH-1:0] = stable;
      ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irq_mask_q;
      ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
      default:      ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_mask_q <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
    end else begin
      irq_mask_q <= irq_mask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edgecap_q & irq_mask_q);

endmodule
